// File: rtl/onewire_master_if.sv
// ============================================================================
// Module      : onewire_master_if
// Description : Command/response bundle between a 1-Wire sequencer and the
//               byte-level 1-Wire bus master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface onewire_master_if;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd;
  logic [7:0] i_wdata;
  logic       o_done;
  logic [7:0] o_rdata;
  logic       o_presence;

  // Sequencer side: issues commands, consumes results
  modport master (
    output i_cmd_valid, i_cmd, i_wdata,
    input  o_cmd_ready, o_done, o_rdata, o_presence
  );

  // Bus-master side: accepts commands, produces results
  modport slave (
    input  i_cmd_valid, i_cmd, i_wdata,
    output o_cmd_ready, o_done, o_rdata, o_presence
  );
endinterface

`default_nettype wire

// File: rtl/onewire_master.sv
// ============================================================================
// Module      : onewire_master
// Description : Byte-level 1-Wire bus master. Generates reset/presence and
//               LSB-first write/read time slots on DQ, timed by a cycle
//               counter scaled by CLK_PER_US.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onewire_master #(
  parameter int CLK_PER_US = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,          // asynchronous, active low
  onewire_master_if.slave bus,
  input  wire logic       I_ONE_WIRE,
  output logic            O_ONE_WIRE
);

  localparam int c_cnt_w = $clog2(480 * CLK_PER_US + 1);

  // Terminal counts are "duration - 1" because the counter starts at 0 on entry
  localparam logic [c_cnt_w-1:0] c_rst_last   = c_cnt_w'(480 * CLK_PER_US - 1);
  localparam logic [c_cnt_w-1:0] c_pres_pt    = c_cnt_w'(70 * CLK_PER_US - 1);
  localparam logic [c_cnt_w-1:0] c_long_last  = c_cnt_w'(60 * CLK_PER_US - 1);
  localparam logic [c_cnt_w-1:0] c_short_last = c_cnt_w'(6 * CLK_PER_US - 1);
  // Release time that completes a 70 us slot after a 6 us or 60 us low phase
  localparam logic [c_cnt_w-1:0] c_rel_long   = c_cnt_w'(64 * CLK_PER_US - 1);
  localparam logic [c_cnt_w-1:0] c_rel_short  = c_cnt_w'(10 * CLK_PER_US - 1);
  // Read sample sits 15 us into the slot, i.e. 9 us after the 6 us low phase
  localparam logic [c_cnt_w-1:0] c_rd_pt      = c_cnt_w'(9 * CLK_PER_US - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_LOW  = 3'd1,
    RST_REL  = 3'd2,
    SLOT_LOW = 3'd3,
    SLOT_REL = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_bit;
  logic [7:0]           r_shreg;
  logic                 r_is_read;
  logic                 r_dq;
  logic                 r_ready;
  logic                 r_done;
  logic [7:0]           r_rdata;
  logic                 r_presence;
  logic                 r_sync1;
  logic                 r_sync2;

  logic                 w_short;
  logic [c_cnt_w-1:0]   w_low_last;
  logic [c_cnt_w-1:0]   w_rel_last;

  // A read slot or a write-1 slot uses the short low phase
  assign w_short    = r_is_read | r_shreg[0];
  assign w_low_last = w_short ? c_short_last : c_long_last;
  assign w_rel_last = w_short ? c_rel_long : c_rel_short;

  assign O_ONE_WIRE      = r_dq;
  assign bus.o_cmd_ready = r_ready;
  assign bus.o_done      = r_done;
  assign bus.o_rdata     = r_rdata;
  assign bus.o_presence  = r_presence;

  // Two-flop synchronizer for the asynchronous DQ line; idles at released level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= I_ONE_WIRE;
      r_sync2 <= r_sync1;
    end
  end

  // Bus sequencing FSM with registered DQ drive and handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_shreg    <= 8'h00;
      r_is_read  <= 1'b0;
      r_dq       <= 1'b1;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_rdata    <= 8'h00;
      r_presence <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_dq  <= 1'b1;
          if (bus.i_cmd_valid && r_ready) begin
            r_ready   <= 1'b0;
            r_bit     <= 3'd0;
            r_shreg   <= bus.i_wdata;
            r_is_read <= (bus.i_cmd == 2'b10);
            case (bus.i_cmd)
              2'b00: begin
                r_state <= RST_LOW;
                r_dq    <= 1'b0;
              end
              2'b01, 2'b10: begin
                r_state <= SLOT_LOW;
                r_dq    <= 1'b0;
              end
              default: begin
                // Reserved command: complete without touching the bus
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end

        RST_LOW: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_rst_last) begin
            r_cnt   <= '0;
            r_dq    <= 1'b1;
            r_state <= RST_REL;
          end
        end

        RST_REL: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_pres_pt) begin
            r_presence <= ~r_sync2;
          end
          if (r_cnt == c_rst_last) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        SLOT_LOW: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (r_cnt == w_low_last) begin
            r_cnt   <= '0;
            r_dq    <= 1'b1;
            r_state <= SLOT_REL;
          end
        end

        SLOT_REL: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          // Read data enters at the MSB so eight right shifts leave bit 0 first-received
          if (r_is_read && (r_cnt == c_rd_pt)) begin
            r_shreg <= {r_sync2, r_shreg[7:1]};
          end
          if (r_cnt == w_rel_last) begin
            r_cnt <= '0;
            if (!r_is_read) begin
              r_shreg <= {1'b0, r_shreg[7:1]};
            end
            if (r_bit == 3'd7) begin
              r_done  <= 1'b1;
              r_state <= DONE;
              if (r_is_read) begin
                r_rdata <= r_shreg;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_dq    <= 1'b0;
              r_state <= SLOT_LOW;
            end
          end
        end

        DONE: begin
          r_cnt   <= '0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_cnt   <= '0;
          r_dq    <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/onewire_master.md
# onewire_master

Byte-level 1-Wire bus master that generates the reset/presence sequence and the write/read time slots on the shared DQ line. It sits directly below the DS18B20 temperature sequencer: the sequencer issues reset, write-byte and read-byte commands, and this block drives `O_ONE_WIRE`/samples `I_ONE_WIRE` with the slot timing the sensor requires. All bus timing is derived from a cycle counter scaled by `CLK_PER_US`; the default design clock is 1 MHz, so 1 cycle = 1 µs.

## Interface
- `CLK_PER_US`, default 1: clock cycles per microsecond. Every timing constant below, given in µs, is multiplied by this value.
- `clk` in 1: design clock.
- `rst` in 1: asynchronous, active-low reset.
- `i_cmd_valid` in 1: command request.
- `o_cmd_ready` out 1: high only in IDLE. A command is accepted when `i_cmd_valid & o_cmd_ready`.
- `i_cmd` in 2: 00 = bus reset, 01 = write byte, 10 = read byte, 11 = reserved.
- `i_wdata` in 8: byte to write, captured at acceptance.
- `o_done` out 1: one-cycle pulse when a command completes.
- `o_rdata` out 8: last byte read. Holds its value until the next read completes.
- `o_presence` out 1: result of the last bus reset. 1 = a slave pulled the line low.
- `I_ONE_WIRE` in 1: raw DQ line level. It is asynchronous to `clk`.
- `O_ONE_WIRE` out 1: 0 = drive DQ low, 1 = release DQ. The external pull-up makes a released line read high.

## Operation
- Input path: `I_ONE_WIRE` passes through a two-flop synchronizer. All sampling uses the synchronized value.
- Bit order: bytes are shifted LSB first. A 3-bit counter counts bit slots 0..7.
- States are IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL and DONE.
- IDLE:
  - `O_ONE_WIRE` = 1 and `o_cmd_ready` = 1.
  - On acceptance: cmd 00 goes to RST_LOW; cmd 01 or 10 goes to SLOT_LOW with the bit counter at 0.
  - On cmd 11: no bus activity, go to DONE.
- RST_LOW: drive low for 480 µs, then go to RST_REL.
- RST_REL:
  - Release the line.
  - Sample the line at 70 µs after release; `o_presence` = NOT(sample).
  - At 480 µs after release, go to DONE.
- SLOT_LOW: drive low for a time set by the command and bit.
  - Write 0: 60 µs.
  - Write 1: 6 µs.
  - Read: 6 µs.
- SLOT_REL:
  - Release the line until the slot reaches 70 µs total, measured from slot start.
  - Read sampling: the line is sampled at 15 µs from slot start, and the sampled value is shifted in as the MSB of the shift register (right shift).
  - Write 0 spends 10 µs in SLOT_REL, which is the recovery time.
  - After bit 7, go to DONE; otherwise increment the bit counter and return to SLOT_LOW.
- DONE:
  - Pulse `o_done` for one cycle.
  - For a read, load `o_rdata` from the shift register in the same cycle.
  - Return to IDLE.
- Commands presented while busy are not accepted. `i_wdata` is ignored outside acceptance.
- Counter width: enough bits to hold 480·`CLK_PER_US`. The counter resets to 0 on every state entry.
- Reset mid-operation:
  - `rst` low forces IDLE immediately, with `O_ONE_WIRE` = 1 (bus released).
  - No `o_done` is produced for the aborted command.
  - Partial read data is discarded.

## Timing
- Reset values: `O_ONE_WIRE` = 1, `o_cmd_ready` = 1, `o_done` = 0, `o_rdata` = 0x00, `o_presence` = 0. The synchronizer flops reset to 1.
- All timings below use `CLK_PER_US` = 1.
- Acceptance is at cycle 0.
  - `O_ONE_WIRE` first goes low at cycle 1.
  - `o_cmd_ready` goes low at cycle 1.
- Bus reset:
  - The line is low for exactly 480 cycles and released for exactly 480 cycles.
  - `o_presence` updates at release + 70.
  - `o_done` fires in the cycle after the 480 released cycles; `o_cmd_ready` returns 1 in the following cycle.
- Byte command:
  - 8 contiguous slots of 70 cycles each, so 560 cycles of bus activity.
  - `o_done` at cycle 561.
  - Back-to-back slots have no gap beyond the slot's own release time.
- Synchronizer latency: 2 cycles. Sample points refer to the synchronized value, so line events must be stable for 2 cycles before a sample point to be seen at it.

## Test plan
- Reset with slave: slave pulls DQ low from release+20 to release+220 → `O_ONE_WIRE` is low for 480 cycles, `o_presence` = 1, one `o_done` pulse.
- Reset, no slave: line stays high → `o_presence` = 0; `o_done` arrives 961 cycles after acceptance.
- Write 0xCC → low pulses of 60, 60, 6, 6, 60, 60, 6, 6 cycles, each slot 70 cycles, then `o_done`.
- Read with the slave holding DQ low for 30 cycles in slots 1 and 4 (line high otherwise) → `o_rdata` = 0xED.
- Command while busy: assert `i_cmd_valid` mid-read → command is not accepted and bus timing is unchanged. Reserved cmd 11 in IDLE → `o_done` with no bus activity.
- Assert `rst` in the 3rd SLOT_LOW of a write → `O_ONE_WIRE` = 1 immediately, no `o_done`. After release of reset, a fresh read completes normally.
